// File: rtl/video_pattern_gen.sv
// Self-timed raster generator with nine selectable test patterns.
// Optional TPG_ANIMATION_EN macro builds the bouncing box used by pattern 8.
module video_pattern_gen #(
  parameter int unsigned VIDEO_WIDTH      = 4,
  parameter int unsigned ACTIVE_COLS      = 640,
  parameter int unsigned ACTIVE_ROWS      = 480,
  parameter int unsigned FRONT_PORCH_HORZ = 16,
  parameter int unsigned SYNC_HORZ        = 96,
  parameter int unsigned BACK_PORCH_HORZ  = 48,
  parameter int unsigned FRONT_PORCH_VERT = 10,
  parameter int unsigned SYNC_VERT        = 2,
  parameter int unsigned BACK_PORCH_VERT  = 33,
  parameter logic        SYNC_POL         = 1'b0,
  parameter int unsigned COUNT_WIDTH      = 11,
  parameter int unsigned RAMP_SHIFT       = 5,
  parameter int unsigned BOX_SIZE         = 32
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [3:0]             i_Pattern,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_HBlank,
  output logic                   o_VBlank,
  output logic                   o_Active,
  output logic                   o_Frame_Start,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic [3:0]             o_Pattern
);

  localparam int unsigned TOTAL_COLS = ACTIVE_COLS + FRONT_PORCH_HORZ + SYNC_HORZ + BACK_PORCH_HORZ;
  localparam int unsigned TOTAL_ROWS = ACTIVE_ROWS + FRONT_PORCH_VERT + SYNC_VERT + BACK_PORCH_VERT;
  localparam int unsigned HS_START   = ACTIVE_COLS + FRONT_PORCH_HORZ;
  localparam int unsigned HS_END     = HS_START + SYNC_HORZ;
  localparam int unsigned VS_START   = ACTIVE_ROWS + FRONT_PORCH_VERT;
  localparam int unsigned VS_END     = VS_START + SYNC_VERT;
  localparam int unsigned BAR_W      = ACTIVE_COLS / 8;

  logic [COUNT_WIDTH-1:0] col, row;
  logic                   col_last_c, row_last_c, frame_start_c;
  logic                   hblank_c, vblank_c, active_c, hsync_c, vsync_c, border_c;
  logic [3:0]             pattern_reg, cur_pat_c;
  logic [2:0]             bar_c;
  logic [VIDEO_WIDTH-1:0] ramp_c, red_c, grn_c, blu_c;
  logic [VIDEO_WIDTH-1:0] all_f;

  assign all_f         = {VIDEO_WIDTH{1'b1}};
  assign col_last_c    = (col == COUNT_WIDTH'(TOTAL_COLS - 1));
  assign row_last_c    = (row == COUNT_WIDTH'(TOTAL_ROWS - 1));
  assign frame_start_c = (col == '0) && (row == '0);

  // Free-running raster counters
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col <= '0;
      row <= '0;
    end else if (col_last_c) begin
      col <= '0;
      row <= row_last_c ? '0 : row + COUNT_WIDTH'(1);
    end else begin
      col <= col + COUNT_WIDTH'(1);
    end
  end

  // Pattern request is taken only at pixel (0,0); that pixel already uses it
  always_ff @(posedge i_Clk) begin
    if (i_Rst)              pattern_reg <= '0;
    else if (frame_start_c) pattern_reg <= i_Pattern;
  end
  assign cur_pat_c = frame_start_c ? i_Pattern : pattern_reg;

`ifdef TPG_ANIMATION_EN
  localparam int unsigned BOX_X_MAX = ACTIVE_COLS - BOX_SIZE;
  localparam int unsigned BOX_Y_MAX = ACTIVE_ROWS - BOX_SIZE;

  logic [COUNT_WIDTH-1:0] box_x, box_y;
  logic                   dir_x, dir_y, in_box_c;

  // Box steps on the frame wrap so the new position is live from pixel (0,0)
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (col_last_c && row_last_c) begin
      if (dir_x) begin
        box_x <= box_x + COUNT_WIDTH'(1);
        if (box_x == COUNT_WIDTH'(BOX_X_MAX - 1)) dir_x <= 1'b0;
      end else begin
        box_x <= box_x - COUNT_WIDTH'(1);
        if (box_x == COUNT_WIDTH'(1)) dir_x <= 1'b1;
      end
      if (dir_y) begin
        box_y <= box_y + COUNT_WIDTH'(1);
        if (box_y == COUNT_WIDTH'(BOX_Y_MAX - 1)) dir_y <= 1'b0;
      end else begin
        box_y <= box_y - COUNT_WIDTH'(1);
        if (box_y == COUNT_WIDTH'(1)) dir_y <= 1'b1;
      end
    end
  end

  assign in_box_c = (col >= box_x) && (col < box_x + COUNT_WIDTH'(BOX_SIZE)) &&
                    (row >= box_y) && (row < box_y + COUNT_WIDTH'(BOX_SIZE));
`endif

  assign hblank_c = (col >= COUNT_WIDTH'(ACTIVE_COLS));
  assign vblank_c = (row >= COUNT_WIDTH'(ACTIVE_ROWS));
  assign active_c = !hblank_c && !vblank_c;
  assign hsync_c  = (col >= COUNT_WIDTH'(HS_START)) && (col < COUNT_WIDTH'(HS_END));
  assign vsync_c  = (row >= COUNT_WIDTH'(VS_START)) && (row < COUNT_WIDTH'(VS_END));
  assign border_c = (col < COUNT_WIDTH'(2)) || (col >= COUNT_WIDTH'(ACTIVE_COLS - 2)) ||
                    (row < COUNT_WIDTH'(2)) || (row >= COUNT_WIDTH'(ACTIVE_ROWS - 2));
  // Columns past the eighth full bar fold into the white bar
  assign bar_c    = (col >= COUNT_WIDTH'(7 * BAR_W)) ? 3'd7 : 3'(col / COUNT_WIDTH'(BAR_W));
  assign ramp_c   = VIDEO_WIDTH'(col >> RAMP_SHIFT);

  // Pattern renderer
  always_comb begin
    red_c = '0;
    grn_c = '0;
    blu_c = '0;
    if (active_c) begin
      case (cur_pat_c)
        4'd1: red_c = all_f;
        4'd2: grn_c = all_f;
        4'd3: blu_c = all_f;
        4'd4: if (col[5] ^ row[5]) begin
          red_c = all_f;
          grn_c = all_f;
          blu_c = all_f;
        end
        4'd5: begin
          red_c = bar_c[2] ? all_f : '0;
          grn_c = bar_c[1] ? all_f : '0;
          blu_c = bar_c[0] ? all_f : '0;
        end
        4'd6: if (border_c) begin
          red_c = all_f;
          grn_c = all_f;
          blu_c = all_f;
        end
        4'd7: begin
          red_c = ramp_c;
          grn_c = ramp_c;
          blu_c = ramp_c;
        end
`ifdef TPG_ANIMATION_EN
        4'd8: if (in_box_c) begin
          red_c = all_f;
          grn_c = all_f;
          blu_c = all_f;
        end
`endif
        default: ;
      endcase
    end
  end

  // Single aligned output stage
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_HSync       <= ~SYNC_POL;
      o_VSync       <= ~SYNC_POL;
      o_HBlank      <= 1'b1;
      o_VBlank      <= 1'b1;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Red_Video   <= '0;
      o_Grn_Video   <= '0;
      o_Blu_Video   <= '0;
      o_Pattern     <= '0;
    end else begin
      o_HSync       <= hsync_c ? SYNC_POL : ~SYNC_POL;
      o_VSync       <= vsync_c ? SYNC_POL : ~SYNC_POL;
      o_HBlank      <= hblank_c;
      o_VBlank      <= vblank_c;
      o_Active      <= active_c;
      o_Frame_Start <= frame_start_c;
      o_Red_Video   <= red_c;
      o_Grn_Video   <= grn_c;
      o_Blu_Video   <= blu_c;
      o_Pattern     <= cur_pat_c;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a shrunken raster: per-cycle reference model,
// a table of hand-derived pixels, and hand sequences for timing and frame sync.
module tb_video_pattern_gen;

  localparam int VW = 4, AC = 44, AR = 10;
  localparam int FPH = 4, SYH = 6, BPH = 4, FPV = 1, SYV = 2, BPV = 1;
  localparam int CW = 7, RS = 1, BS = 8;
  localparam logic SP = 1'b0;
  localparam int TC = AC + FPH + SYH + BPH;
  localparam int TR = AR + FPV + SYV + BPV;
  localparam int FRAME = TC * TR;
  localparam int BARW = AC / 8;
  localparam logic [3:0] F = 4'hF;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] pat_in;
  logic hs, vs, hb, vb, act, fs;
  logic [VW-1:0] red, grn, blu;
  logic [3:0] pat_out;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .VIDEO_WIDTH(VW), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .FRONT_PORCH_HORZ(FPH), .SYNC_HORZ(SYH), .BACK_PORCH_HORZ(BPH),
    .FRONT_PORCH_VERT(FPV), .SYNC_VERT(SYV), .BACK_PORCH_VERT(BPV),
    .SYNC_POL(SP), .COUNT_WIDTH(CW), .RAMP_SHIFT(RS), .BOX_SIZE(BS)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Pattern(pat_in),
    .o_HSync(hs), .o_VSync(vs), .o_HBlank(hb), .o_VBlank(vb),
    .o_Active(act), .o_Frame_Start(fs),
    .o_Red_Video(red), .o_Grn_Video(grn), .o_Blu_Video(blu),
    .o_Pattern(pat_out)
  );

  typedef struct packed {
    logic hs, vs, hb, vb, act, fs;
    logic [3:0] r, g, b, pat;
  } obs_t;

  typedef struct {
    logic [3:0] pat;
    int col, row;
    logic [3:0] r, g, b;
    logic act;
  } vec_t;

  int checks = 0, passes = 0;
  int k = 0, last_idx = -1;
  logic [3:0] mpat = 4'd0;

  // Bouncing position as a triangle wave over the frame number
  function automatic int tri_pos(int f, int lim);
    int m;
    m = f % (2 * lim);
    return (m <= lim) ? m : 2 * lim - m;
  endfunction

  function automatic obs_t model(int idx, logic [3:0] pat);
    obs_t o;
    int c, r, f, bar, v;
    o = '0;
    c = idx % TC;
    r = (idx / TC) % TR;
    f = idx / FRAME;
    o.hs  = (c >= AC + FPH && c < AC + FPH + SYH) ? SP : ~SP;
    o.vs  = (r >= AR + FPV && r < AR + FPV + SYV) ? SP : ~SP;
    o.hb  = (c >= AC);
    o.vb  = (r >= AR);
    o.act = (c < AC) && (r < AR);
    o.fs  = (c == 0) && (r == 0);
    o.pat = pat;
    if (o.act) begin
      case (int'(pat))
        1: o.r = F;
        2: o.g = F;
        3: o.b = F;
        4: if (((c / 32) % 2) != ((r / 32) % 2)) begin o.r = F; o.g = F; o.b = F; end
        5: begin
          bar = c / BARW;
          if (bar > 7) bar = 7;
          o.r = ((bar / 4) % 2 == 1) ? F : 4'h0;
          o.g = ((bar / 2) % 2 == 1) ? F : 4'h0;
          o.b = (bar % 2 == 1) ? F : 4'h0;
        end
        6: if (c < 2 || c >= AC - 2 || r < 2 || r >= AR - 2) begin o.r = F; o.g = F; o.b = F; end
        7: begin
          v = (c >> RS) % 16;
          o.r = 4'(v); o.g = 4'(v); o.b = 4'(v);
        end
`ifdef TPG_ANIMATION_EN
        8: begin
          int bx, by;
          bx = tri_pos(f, AC - BS);
          by = tri_pos(f, AR - BS);
          if (c >= bx && c < bx + BS && r >= by && r < by + BS) begin o.r = F; o.g = F; o.b = F; end
        end
`endif
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // One clock: advance the model and compare every output
  task automatic step();
    obs_t e, got;
    @(posedge clk);
    if (rst) begin
      e = '0;
      e.hs = ~SP; e.vs = ~SP; e.hb = 1'b1; e.vb = 1'b1;
      k = 0;
      last_idx = -1;
    end else begin
      if (k % FRAME == 0) mpat = pat_in;
      e = model(k, mpat);
      last_idx = k;
      k++;
    end
    #1;
    got = {hs, vs, hb, vb, act, fs, red, grn, blu, pat_out};
    checks++;
    if (got === e) passes++;
    else $display("FAIL px%0d: got %h expected %h", last_idx, got, e);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!fs && n < 2 * FRAME);
    if (!fs) check_int("fs_timeout", 0, 1);
  endtask

  task automatic run_to(int col, int row);
    int n;
    n = 0;
    while ((last_idx < 0 || last_idx % FRAME != row * TC + col) && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  vec_t vecs[19];

  initial begin
    int a, n, cnt, vrow;
    logic red_ok;

    vecs[0]  = '{4'd5,  4, 0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[1]  = '{4'd5,  5, 0, 4'h0, 4'h0, F,    1'b1};
    vecs[2]  = '{4'd5, 30, 3, F,    F,    4'h0, 1'b1};
    vecs[3]  = '{4'd5, 35, 0, F,    F,    F,    1'b1};
    vecs[4]  = '{4'd5, 42, 0, F,    F,    F,    1'b1};
    vecs[5]  = '{4'd5, 44, 0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{4'd7,  1, 2, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[7]  = '{4'd7,  2, 2, 4'h1, 4'h1, 4'h1, 1'b1};
    vecs[8]  = '{4'd7, 31, 2, F,    F,    F,    1'b1};
    vecs[9]  = '{4'd7, 32, 2, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[10] = '{4'd4, 31, 0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[11] = '{4'd4, 32, 0, F,    F,    F,    1'b1};
    vecs[12] = '{4'd6,  1, 5, F,    F,    F,    1'b1};
    vecs[13] = '{4'd6,  2, 5, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[14] = '{4'd6, 43, 9, F,    F,    F,    1'b1};
    vecs[15] = '{4'd6, 20, 8, F,    F,    F,    1'b1};
    vecs[16] = '{4'd1, 10, 3, F,    4'h0, 4'h0, 1'b1};
    vecs[17] = '{4'd12,10, 3, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[18] = '{4'd3,  0, 0, 4'h0, 4'h0, F,    1'b1};

    rst = 1'b1;
    pat_in = 4'd0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_int("fs_after_release", int'(fs), 1);

    // HSync position, width and line period
    n = 0;
    while (hs != SP && n < 2 * TC) begin step(); n++; end
    a = last_idx;
    check_int("hsync_start_col", a % TC, AC + FPH);
    cnt = 1;
    n = 0;
    while (n < TC) begin
      step(); n++;
      if (hs == SP) cnt++;
      else break;
    end
    check_int("hsync_width", cnt, SYH);
    n = 0;
    while (hs != SP && n < 2 * TC) begin step(); n++; end
    check_int("line_period", last_idx - a, TC);

    // VSync rows and frame period
    wait_fs();
    cnt = 0;
    vrow = -1;
    for (int i = 1; i < FRAME; i++) begin
      step();
      if (vs == SP) begin
        cnt++;
        if (vrow < 0) vrow = (i / TC);
      end
    end
    check_int("vsync_first_row", vrow, AR + FPV);
    check_int("vsync_cycles", cnt, SYV * TC);
    step();
    check_int("frame_period_fs", int'(fs), 1);

    // Mid-frame pattern change takes effect only at the next frame
    pat_in = 4'd1;
    wait_fs();
    run_to(0, 5);
    pat_in = 4'd2;
    red_ok = 1'b1;
    n = 0;
    while (n < 2 * FRAME) begin
      step(); n++;
      if (fs) break;
      if (act && red != F) red_ok = 1'b0;
    end
    check_int("chg_red_persists", int'(red_ok), 1);
    check_int("chg_pat_at_fs", int'(pat_out), 2);
    check_int("chg_grn_at_fs", int'(grn), int'(F));

    // Hand-derived pixel table
    foreach (vecs[i]) begin
      pat_in = vecs[i].pat;
      wait_fs();
      run_to(vecs[i].col, vecs[i].row);
      check_int($sformatf("vec%0d", i), int'({red, grn, blu, act}),
                int'({vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].act}));
    end

    // Mid-line reset, then a full box sweep through the reversal
    run_to(20, 3);
    rst = 1'b1;
    pat_in = 4'd8;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_int("fs_after_mid_reset", int'(fs), 1);
    for (int i = 0; i < 38 * FRAME; i++) begin
      step();
`ifdef TPG_ANIMATION_EN
      if (last_idx == 3 * FRAME + TC + 3)   check_int("box_f3_in",    int'(red), int'(F));
      if (last_idx == 3 * FRAME + TC + 11)  check_int("box_f3_right", int'(red), 0);
      if (last_idx == 37 * FRAME + TC + 35) check_int("box_f37_in",   int'(red), int'(F));
      if (last_idx == 37 * FRAME + TC + 34) check_int("box_f37_left", int'(red), 0);
`else
      if (last_idx == 3 * FRAME + TC + 3)   check_int("box_off_black", int'(red), 0);
`endif
    end

    // Random pattern requests at random times
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 199) == 0) pat_in = 4'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
